// File: rtl/sccb_config_seq.sv
// SCCB register-table configuration sequencer.
// Walks a registered ROM of {sub-address, value} words and issues one 3-phase
// SCCB write per entry. It supports an inline delay entry (sub == DELAY_REG)
// and an end marker (16'hFFFF). All pin outputs are registered.
//
// Control handshake: START is a single-cycle pulse that is accepted only in
// IDLE. Acceptance raises BUSY on the next cycle. BUSY drops in the same cycle
// that DONE rises. START pulses seen while not in IDLE are ignored. DONE and
// ACK_ERR hold their values until the next accepted START.
module sccb_config_seq #(
    parameter int          CLK_DIV      = 250,
    parameter logic [7:0]  SLAVE_ID     = 8'h42,
    parameter logic [31:0] DELAY_CYCLES = 32'd1000000,
    parameter logic [7:0]  DELAY_REG    = 8'hFE
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ACK_ERR,
    output logic [7:0]  ROM_ADDR,
    input  logic [15:0] ROM_DATA,
    output logic        SIO_C,
    output logic        SIO_D_OUT,
    output logic        SIO_D_OE,
    input  logic        SIO_D_IN,
    output logic [3:0]  STATE_DBG
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_START_C, S_TX,
        S_STOP, S_GAP, S_ADVANCE, S_DELAY, S_FINISH
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [1:0]       qtr, qtr_n;          // quarter of the current SCCB bit/phase
    logic [4:0]       bit_idx, bit_n;      // 0-based bit within the 27-bit word
    logic [26:0]      shreg, shreg_n;      // MSB is the bit currently on the bus
    logic [31:0]      dly_cnt, dly_n;
    logic [7:0]       addr_n;
    logic             busy_n, done_n, ack_n;
    logic             c_n, d_n, oe_n;
    logic             tick;

    // The 9th bit of each phase is the don't-care/ACK slot, where the bus is released.
    function automatic logic is_ack_bit(input logic [4:0] b);
        return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
    endfunction

    assign tick      = (div_cnt == DIV_LAST);
    assign STATE_DBG = state;

    // State and registered pins; reset forces an idle bus without a stop condition.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            qtr       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            dly_cnt   <= '0;
            ROM_ADDR  <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ACK_ERR   <= 1'b0;
            SIO_C     <= 1'b1;
            SIO_D_OUT <= 1'b1;
            SIO_D_OE  <= 1'b1;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            qtr       <= qtr_n;
            bit_idx   <= bit_n;
            shreg     <= shreg_n;
            dly_cnt   <= dly_n;
            ROM_ADDR  <= addr_n;
            BUSY      <= busy_n;
            DONE      <= done_n;
            ACK_ERR   <= ack_n;
            SIO_C     <= c_n;
            SIO_D_OUT <= d_n;
            SIO_D_OE  <= oe_n;
        end
    end

    // Next-state logic, then pin values derived from where the FSM is heading.
    always_comb begin
        state_n = state;
        qtr_n   = qtr;
        bit_n   = bit_idx;
        shreg_n = shreg;
        dly_n   = dly_cnt;
        addr_n  = ROM_ADDR;
        busy_n  = BUSY;
        done_n  = DONE;
        ack_n   = ACK_ERR;

        // The divider is held while idle and free-runs everywhere else.
        if (state == S_IDLE || state == S_FINISH || tick) div_n = '0;
        else                                               div_n = div_cnt + DIV_W'(1);

        case (state)
            S_IDLE: begin
                if (START) begin
                    addr_n  = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    ack_n   = 1'b0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (ROM_DATA == 16'hFFFF) begin
                    state_n = S_FINISH;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (ROM_DATA[15:8] == DELAY_REG) begin
                    dly_n   = DELAY_CYCLES;
                    state_n = S_DELAY;
                end else begin
                    shreg_n = {SLAVE_ID, 1'b1, ROM_DATA[15:8], 1'b1, ROM_DATA[7:0], 1'b1};
                    div_n   = '0;
                    qtr_n   = 2'd0;
                    bit_n   = 5'd0;
                    state_n = S_START_C;
                end
            end
            S_START_C: begin
                if (tick) begin
                    qtr_n = qtr + 2'd1;
                    if (qtr == 2'd3) begin
                        bit_n   = 5'd0;
                        state_n = S_TX;
                    end
                end
            end
            S_TX: begin
                if (tick) begin
                    qtr_n = qtr + 2'd1;
                    if (qtr == 2'd2 && is_ack_bit(bit_idx) && SIO_D_IN) ack_n = 1'b1;
                    if (qtr == 2'd3) begin
                        if (bit_idx == 5'd26) begin
                            state_n = S_STOP;
                        end else begin
                            bit_n   = bit_idx + 5'd1;
                            shreg_n = {shreg[25:0], 1'b0};
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    qtr_n = qtr + 2'd1;
                    if (qtr == 2'd3) state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    qtr_n = qtr + 2'd1;
                    if (qtr == 2'd3) state_n = S_ADVANCE;
                end
            end
            S_ADVANCE, S_DELAY: begin
                if (state == S_DELAY && dly_cnt != 32'd0) begin
                    dly_n = dly_cnt - 32'd1;
                end else if (ROM_ADDR == 8'hFF) begin
                    // The table ends after the last entry even without a marker.
                    state_n = S_FINISH;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    addr_n  = ROM_ADDR + 8'd1;
                    state_n = S_FETCH;
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        // Idle bus by default: clock high, data high and driven.
        c_n  = 1'b1;
        d_n  = 1'b1;
        oe_n = 1'b1;
        case (state_n)
            S_START_C: d_n = (qtr_n < 2'd2);
            S_TX: begin
                c_n  = qtr_n[1];
                d_n  = shreg_n[26];
                oe_n = !is_ack_bit(bit_n);
            end
            S_STOP: begin
                c_n = qtr_n[1];
                d_n = (qtr_n == 2'd3);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sccb_config_seq.sv
// Bench for sccb_config_seq: table-driven cases plus hand-written reset, ACK,
// repeated-START and unterminated-table sequences, with a bus-decoding scoreboard.
`timescale 1ns/1ps
module tb_sccb_config_seq;

    localparam int CLK_DIV = 4;
    localparam int QBIT    = 4 * CLK_DIV;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, start, sio_d_in;
    logic        busy, done, ack_err, sio_c, sio_d_out, sio_d_oe;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [3:0]  state_dbg;
    logic [15:0] rom [0:255];

    // Registered table ROM: data valid one clock after the address changes.
    always @(posedge clk) rom_data <= rom[rom_addr];

    sccb_config_seq #(
        .CLK_DIV(CLK_DIV), .SLAVE_ID(8'h42), .DELAY_CYCLES(32'd100), .DELAY_REG(8'hFE)
    ) dut (
        .CLK(clk), .RESETN(resetn), .START(start), .BUSY(busy), .DONE(done),
        .ACK_ERR(ack_err), .ROM_ADDR(rom_addr), .ROM_DATA(rom_data), .SIO_C(sio_c),
        .SIO_D_OUT(sio_d_out), .SIO_D_OE(sio_d_oe), .SIO_D_IN(sio_d_in), .STATE_DBG(state_dbg)
    );

    // Second instance, faster divider, for the 256-entry unterminated table.
    logic        resetn2, start2, busy2, done2, ack2, sio_c2, sio_d2, oe2;
    logic [7:0]  rom_addr2;
    logic [15:0] rom_data2;
    logic [3:0]  state2;
    always @(posedge clk) rom_data2 <= 16'h0101;

    sccb_config_seq #(.CLK_DIV(2)) dut2 (
        .CLK(clk), .RESETN(resetn2), .START(start2), .BUSY(busy2), .DONE(done2),
        .ACK_ERR(ack2), .ROM_ADDR(rom_addr2), .ROM_DATA(rom_data2), .SIO_C(sio_c2),
        .SIO_D_OUT(sio_d2), .SIO_D_OE(oe2), .SIO_D_IN(1'b0), .STATE_DBG(state2)
    );

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- scoreboard / bus monitor ----------------
    logic [23:0] exp_q[$];
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          mon_en = 1'b0;
    bit          in_txn = 1'b0;
    bit          per_bad;
    int          cfalls, nbits, last_rise, txn_cnt = 0;
    int          stop_cyc = 0, last_gap = 0;
    int          force_txn = -1, force_bit = 0;
    logic [26:0] cap, oe_cap;
    logic        pc = 1'b1, pd = 1'b1;

    task automatic check_txn();
        logic [23:0] exp;
        check("txn_expected_avail", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("txn_word", {8'h0, cap[26:19], cap[17:10], cap[8:1]}, {8'h0, exp});
            check("txn_nbits", nbits, 27);
            check("txn_oe", {5'h0, oe_cap}, 32'h07FBFDFE);
            check("sio_c_period", {31'h0, per_bad}, 0);
        end
    endtask

    // Decode start / bits / stop from the registered pins, on the falling edge.
    always @(negedge clk) begin
        if (!mon_en) begin
            in_txn = 1'b0;
        end else if (!in_txn) begin
            if (pc && sio_c && pd && !sio_d_out && sio_d_oe) begin
                in_txn   = 1'b1;
                cfalls   = 0;
                nbits    = 0;
                cap      = '0;
                oe_cap   = '0;
                per_bad  = 1'b0;
                last_gap = cyc - stop_cyc;
            end
        end else if (pc && !sio_c) begin
            cfalls++;
            sio_d_in = (txn_cnt == force_txn && cfalls == force_bit);
        end else if (!pc && sio_c) begin
            if (nbits < 27) begin
                if (nbits > 0 && cyc - last_rise != QBIT) per_bad = 1'b1;
                last_rise = cyc;
                cap       = {cap[25:0], sio_d_out};
                oe_cap    = {oe_cap[25:0], sio_d_oe};
                nbits++;
            end
        end else if (pc && sio_c && !pd && sio_d_out) begin
            in_txn   = 1'b0;
            stop_cyc = cyc;
            check_txn();
            txn_cnt++;
        end
        pc = sio_c;
        pd = sio_d_out;
    end

    // ---------------- driver tasks ----------------
    typedef struct packed {
        logic [3:0][15:0] words;
        logic [3:0]       exp_tx;
        logic [7:0]       last;
        logic             chk_lat;
        logic             chk_gap;
    } case_t;

    task automatic load_rom(input logic [3:0][15:0] words);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        for (int j = 0; j < 4; j++) rom[j] = words[j];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max, output int lat);
        lat = 0;
        while (!done && lat < max) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_done"}, {31'h0, done}, 1);
    endtask

    task automatic run_case(input case_t c, input int idx);
        int lat;
        load_rom(c.words);
        for (int j = 0; j < 4; j++)
            if (c.exp_tx[j]) exp_q.push_back({8'h42, c.words[j]});
        pulse_start();
        check($sformatf("case%0d_busy", idx), {31'h0, busy}, 1);
        wait_done($sformatf("case%0d", idx), 4000, lat);
        if (c.chk_lat) check_range("done_latency", lat, 481, 485);
        if (c.chk_gap) check_range("delay_gap", last_gap, 100, 1000000);
        check($sformatf("case%0d_sb_empty", idx), exp_q.size(), 0);
        check($sformatf("case%0d_rom_addr", idx), {24'h0, rom_addr}, {24'h0, c.last});
        check($sformatf("case%0d_ack_err", idx), {31'h0, ack_err}, 0);
        check($sformatf("case%0d_busy_end", idx), {31'h0, busy}, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_sio_c"}, {31'h0, sio_c}, 1);
        check({name, "_sio_d"}, {31'h0, sio_d_out}, 1);
        check({name, "_oe"}, {31'h0, sio_d_oe}, 1);
        check({name, "_busy"}, {31'h0, busy}, 0);
        check({name, "_state"}, {28'h0, state_dbg}, 0);
    endtask

    bit wrap_done = 1'b0;

    // ---------------- main sequence ----------------
    initial begin
        case_t       cases [4];
        int          lat, k, base;
        logic [7:0]  alog[$];

        cases[0] = '{words: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1280}, exp_tx: 4'b0001,
                     last: 8'd1, chk_lat: 1'b1, chk_gap: 1'b0};
        cases[1] = '{words: {16'hFFFF, 16'h3A04, 16'hFE00, 16'h1101}, exp_tx: 4'b0101,
                     last: 8'd3, chk_lat: 1'b0, chk_gap: 1'b1};
        cases[2] = '{words: {16'h0000, 16'hFFFF, 16'h33AA, 16'h0A55}, exp_tx: 4'b0011,
                     last: 8'd2, chk_lat: 1'b0, chk_gap: 1'b0};
        cases[3] = '{words: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFE12}, exp_tx: 4'b0000,
                     last: 8'd1, chk_lat: 1'b0, chk_gap: 1'b0};

        resetn   = 1'b0;
        start    = 1'b0;
        sio_d_in = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_done", {31'h0, done}, 0);
        check("reset_ack", {31'h0, ack_err}, 0);
        check("reset_addr", {24'h0, rom_addr}, 0);
        resetn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Reset in bit 5 of the second write, then a clean restart from entry 0.
        load_rom({16'hFFFF, 16'hFFFF, 16'h1301, 16'h1280});
        exp_q.push_back(24'h421280);
        exp_q.push_back(24'h421301);
        base = txn_cnt;
        pulse_start();
        k = 0;
        while (!(txn_cnt == base + 1 && in_txn && cfalls == 5) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_range("reach_bit5", k, 0, 2999);
        check("mid_tx_addr", {24'h0, rom_addr}, 1);
        mon_en = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("mid_reset");
        check("mid_reset_addr", {24'h0, rom_addr}, 0);
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
        exp_q.push_back(24'h421280);
        exp_q.push_back(24'h421301);
        pulse_start();
        check("restart_addr", {24'h0, rom_addr}, 0);
        wait_done("restart", 3000, lat);
        check("restart_sb_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Table-driven cases.
        for (int i = 0; i < 4; i++) run_case(cases[i], i);

        // ACK slot held high during bit 18 of the second write only.
        load_rom({16'hFFFF, 16'h5566, 16'h3A04, 16'h1101});
        for (int j = 0; j < 2; j++) begin
            exp_q.push_back(24'h421101);
            exp_q.push_back(24'h423A04);
            exp_q.push_back(24'h425566);
        end
        base      = txn_cnt;
        force_txn = base + 1;
        force_bit = 18;
        pulse_start();
        k = 0;
        while (txn_cnt < base + 1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("ack_clean_first", {31'h0, ack_err}, 0);
        wait_done("ack", 4000, lat);
        check("ack_err_set", {31'h0, ack_err}, 1);
        check("ack_all_written", exp_q.size(), 3);
        force_txn = -1;
        repeat (3) @(negedge clk);
        pulse_start();
        check("ack_cleared", {31'h0, ack_err}, 0);
        check("done_cleared", {31'h0, done}, 0);
        wait_done("ack_rerun", 4000, lat);
        check("ack_rerun_clean", {31'h0, ack_err}, 0);
        check("ack_rerun_sb", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Extra START pulses while busy must not disturb the address sequence.
        load_rom({16'hFFFF, 16'hFFFF, 16'h1301, 16'h1280});
        exp_q.push_back(24'h421280);
        exp_q.push_back(24'h421301);
        pulse_start();
        alog.delete();
        alog.push_back(rom_addr);
        for (k = 0; k < 4000 && !done; k++) begin
            start = busy && (k < 2 || $urandom_range(0, 99) < 3);
            @(negedge clk);
            if (rom_addr != alog[$]) alog.push_back(rom_addr);
        end
        start = 1'b0;
        check("rpt_done", {31'h0, done}, 1);
        check("rpt_addr_count", alog.size(), 3);
        for (int i = 0; i < alog.size(); i++)
            check($sformatf("rpt_addr%0d", i), {24'h0, alog[i]}, i);
        check("rpt_sb_empty", exp_q.size(), 0);

        k = 0;
        while (!wrap_done && k < 100000) begin
            @(negedge clk);
            k++;
        end
        check("wrap_test_finished", {31'h0, wrap_done}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- unterminated 256-entry table on dut2 ----------------
    initial begin
        int   starts, k;
        bit   left0, wrapped;
        logic p2c, p2d;
        starts  = 0;
        left0   = 1'b0;
        wrapped = 1'b0;
        p2c     = 1'b1;
        p2d     = 1'b1;
        resetn2 = 1'b0;
        start2  = 1'b0;
        repeat (3) @(negedge clk);
        resetn2 = 1'b1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (k = 0; k < 70000 && !done2; k++) begin
            @(negedge clk);
            if (p2c && sio_c2 && p2d && !sio_d2) starts++;
            if (rom_addr2 != 8'd0) left0 = 1'b1;
            else if (left0 && !done2) wrapped = 1'b1;
            p2c = sio_c2;
            p2d = sio_d2;
        end
        check("wrap_done", {31'h0, done2}, 1);
        check("wrap_txn_count", starts, 256);
        check("wrap_no_wrap", {31'h0, wrapped}, 0);
        check("wrap_last_addr", {24'h0, rom_addr2}, 255);
        check("wrap_busy_end", {31'h0, busy2}, 0);
        wrap_done = 1'b1;
    end

endmodule
